// File: rtl/toggle_seq_ctrl_pkg.sv
// Shared definitions for the toggle sequencer.
//   state_e     : FSM encoding, also the value driven on the 2-bit state port
//   ST_*        : plain 2-bit constants for code that compares the state port
//   ptr_next    : channel pointer advance with wrap in either direction
package toggle_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  // Up: n-1 wraps to 0. Down: 0 wraps to n-1.
  function automatic int unsigned ptr_next(input int unsigned p, input logic dn,
                                           input int unsigned n);
    if (dn) begin
      return (p == 0) ? n - 1 : p - 1;
    end
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/toggle_seq_ctrl_edge_pulse.sv
// Rising-edge detector for one raw button level.
//   clk   : system clock
//   reset : synchronous, active-high; clears both sample flops
//   in    : raw button level
//   out   : one-cycle pulse, high the cycle after 'in' is first sampled high
module toggle_seq_ctrl_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic a_q, a_d;
  logic b_q, b_d;

  always_comb begin
    a_d = in;
    b_d = a_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // A held level sets both flops, so only the first sampled-high cycle pulses.
  assign out = a_q & ~b_q;

endmodule

// File: rtl/toggle_seq_ctrl.sv
// Sequencer for the T-flip-flop LED bank.
// Turns button presses into one-cycle, one-hot toggle pulses on t_out, one channel at a time,
// either paced by a prescaler (RUN) or one per step press (IDLE / PAUSE).
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high
//   btn_start  : raw level; rising edge = run / pause
//   btn_step   : raw level; rising edge = single step (ignored while running)
//   btn_dir    : raw level; rising edge = flip pointer direction
//   t_out      : one-hot toggle pulse or all zero, registered
//   state      : 00 idle, 01 run, 10 pause
//   ptr        : channel the next toggle will hit
//   dir_dn     : 0 = ptr counts up, 1 = ptr counts down
// PRESCALE must be >= 2 and fit in CNT_W bits; N_CH must be >= 2.
module toggle_seq_ctrl
  import toggle_seq_ctrl_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned PRESCALE = 125000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_start,
  input  logic                    btn_step,
  input  logic                    btn_dir,
  output logic [N_CH-1:0]         t_out,
  output logic [1:0]              state,
  output logic [$clog2(N_CH)-1:0] ptr,
  output logic                    dir_dn
);

  localparam int unsigned PTR_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic start_p, step_p, dir_p;

  toggle_seq_ctrl_edge_pulse u_edge_start (
    .clk   (clk),
    .reset (reset),
    .in    (btn_start),
    .out   (start_p)
  );

  toggle_seq_ctrl_edge_pulse u_edge_step (
    .clk   (clk),
    .reset (reset),
    .in    (btn_step),
    .out   (step_p)
  );

  toggle_seq_ctrl_edge_pulse u_edge_dir (
    .clk   (clk),
    .reset (reset),
    .in    (btn_dir),
    .out   (dir_p)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              dir_q, dir_d;
  logic [N_CH-1:0]   t_out_q, t_out_d;
  logic              fire;
  logic              term;

  assign term = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    // The flip only affects advances after this cycle; this cycle's advance uses dir_q.
    dir_d   = dir_q ^ dir_p;
    fire    = 1'b0;
    t_out_d = '0;

    unique case (state_q)
      StIdle: begin
        // Start wins over a simultaneous step.
        if (start_p) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (step_p) begin
          fire = 1'b1;
        end
      end
      StRun: begin
        if (term) begin
          fire  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
        if (start_p) begin
          state_d = StPause;
          // Hold the count so a resume continues the current period; a terminal
          // count still fires and wraps.
          if (!term) begin
            cnt_d = cnt_q;
          end
        end
      end
      StPause: begin
        if (start_p) begin
          state_d = StRun;
        end else if (step_p) begin
          fire = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fire) begin
      ptr_d = PTR_W'(ptr_next(32'(ptr_q), dir_q, N_CH));
    end

    for (int i = 0; i < int'(N_CH); i++) begin
      t_out_d[i] = fire && (ptr_q == PTR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      t_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      t_out_q <= t_out_d;
    end
  end

  assign t_out  = t_out_q;
  assign state  = state_q;
  assign ptr    = ptr_q;
  assign dir_dn = dir_q;

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Directed bench for toggle_seq_ctrl (N_CH=3, PRESCALE=4, CNT_W=3).
// Inputs change 1 time unit after a rising edge; outputs are read at the same point.
module tb_toggle_seq_ctrl;
  import toggle_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_dir = 1'b0;
  logic [2:0] t_out;
  logic [1:0] state;
  logic [1:0] ptr;
  logic       dir_dn;

  int         n_vec = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [2:0] led_model = 3'b000;  // XOR of every observed t_out pulse
  logic [2:0] exp_led = 3'b000;    // XOR of every pulse the bench expects

  toggle_seq_ctrl #(
    .N_CH     (3),
    .PRESCALE (4),
    .CNT_W    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_step  (btn_step),
    .btn_dir   (btn_dir),
    .t_out     (t_out),
    .state     (state),
    .ptr       (ptr),
    .dir_dn    (dir_dn)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next non-zero t_out and check its value and its distance in cycles.
  task automatic expect_pulse(input string tag, input logic [2:0] exp_t, input int exp_cyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (t_out == 3'b000 && n < exp_cyc + 3);
    check_eq({tag, "_val"}, 32'(t_out), 32'(exp_t));
    check_eq({tag, "_lat"}, n, exp_cyc);
    exp_led ^= exp_t;
  endtask

  // T_FF bank model plus per-cycle invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("onehot", 32'($countones(t_out) <= 1), 32'd1);
      check_eq("state_legal", 32'(state != 2'b11), 32'd1);
      led_model ^= t_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, then idle with no buttons
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    check_eq("rst_ptr", 32'(ptr), 32'd0);
    check_eq("rst_dir", 32'(dir_dn), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_state", 32'(state), 32'(ST_IDLE));
      check_eq("idle_tout", 32'(t_out), 32'd0);
    end
    check_eq("idle_ptr", 32'(ptr), 32'd0);

    // 2: start held 10 cycles -> one entry into RUN, pulses every 4 cycles
    btn_start = 1'b1;
    tick();
    check_eq("start_lat1", 32'(state), 32'(ST_IDLE));
    tick();
    check_eq("start_run", 32'(state), 32'(ST_RUN));
    expect_pulse("run0", 3'b001, 4);
    expect_pulse("run1", 3'b010, 4);
    btn_start = 1'b0;
    check_eq("held_start", 32'(state), 32'(ST_RUN));
    expect_pulse("run2", 3'b100, 4);
    expect_pulse("run3", 3'b001, 4);
    check_eq("run_ptr", 32'(ptr), 32'd1);

    // 3: flip direction right after the 010 pulse; the advance from that pulse was
    //    already up (ptr=2), then pulses go 100, 010, 001 and ptr wraps 0 -> 2
    expect_pulse("run4", 3'b010, 4);
    btn_dir = 1'b1;
    tick();
    tick();
    btn_dir = 1'b0;
    check_eq("dir_flip", 32'(dir_dn), 32'd1);
    expect_pulse("dn0", 3'b100, 2);
    expect_pulse("dn1", 3'b010, 4);
    expect_pulse("dn2", 3'b001, 4);
    check_eq("dn_wrap_ptr", 32'(ptr), 32'd2);

    // 4: flip back to up, then pause on the terminal-count cycle: toggle still fires
    btn_dir = 1'b1;
    tick();
    tick();
    btn_dir = 1'b0;
    check_eq("dir_back", 32'(dir_dn), 32'd0);
    btn_start = 1'b1;
    tick();
    tick();
    check_eq("pause_term_tout", 32'(t_out), 32'b100);
    check_eq("pause_term_state", 32'(state), 32'(ST_PAUSE));
    check_eq("pause_term_ptr", 32'(ptr), 32'd0);
    exp_led ^= 3'b100;
    btn_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("pause_quiet", 32'(t_out), 32'd0);
    end
    check_eq("pause_state", 32'(state), 32'(ST_PAUSE));

    // three step presses in PAUSE, 2 cycles each
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1;
      expect_pulse("step", 3'(1 << i), 2);
      btn_step = 1'b0;
      check_eq("step_state", 32'(state), 32'(ST_PAUSE));
      tick();
      tick();
    end
    check_eq("step_ptr", 32'(ptr), 32'd0);

    // resume, then a step press while running must be ignored
    btn_start = 1'b1;
    tick();
    tick();
    btn_start = 1'b0;
    check_eq("resume", 32'(state), 32'(ST_RUN));
    btn_step = 1'b1;
    tick();
    tick();
    btn_step = 1'b0;
    check_eq("step_in_run", 32'(t_out), 32'd0);
    check_eq("step_in_run_ptr", 32'(ptr), 32'd0);
    expect_pulse("resume0", 3'b001, 2);

    // 5: start and step together from IDLE -> RUN, no step pulse
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst2_state", 32'(state), 32'(ST_IDLE));
    btn_start = 1'b1;
    btn_step = 1'b1;
    tick();
    tick();
    btn_start = 1'b0;
    btn_step = 1'b0;
    check_eq("both_state", 32'(state), 32'(ST_RUN));
    check_eq("both_tout", 32'(t_out), 32'd0);
    check_eq("both_ptr", 32'(ptr), 32'd0);

    // 6: reset sampled on the would-be terminal-count edge -> no pulse, all cleared
    btn_dir = 1'b1;
    tick();
    tick();
    btn_dir = 1'b0;
    check_eq("pre_rst_dir", 32'(dir_dn), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_tout", 32'(t_out), 32'd0);
    check_eq("abort_state", 32'(state), 32'(ST_IDLE));
    check_eq("abort_ptr", 32'(ptr), 32'd0);
    check_eq("abort_dir", 32'(dir_dn), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_abort_tout", 32'(t_out), 32'd0);
    end
    check_eq("post_abort_state", 32'(state), 32'(ST_IDLE));

    check_eq("led_bank", 32'(led_model), 32'(exp_led));
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
